ser_window_arbiter: RTL
=======================

// Module: ser_window_arbiter
// PURPOSE
//  Shares the serial-engine register window (BA13=0, BA12=1) between two requesters: CPU (port 0) and DMA (port 1).
//  Round-robin arbitration; each granted transaction is sequenced onto the window bus:
//  address setup, SSER strobe with programmable wait states, then SDRD sample and ack.
//  Sits between the host bus decode and the serial state-machine PAL.
//  Requests outside the window are rejected without a bus cycle.
// PARAMETERS
//  WAIT_CYCLES  2  cycles SSER held low before SDRD is sampled (1..15)
//  SETUP_CYCLES 1  cycles address/BR_W held stable before SSER falls (1..3)
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst         in   1   synchronous, active-high reset
//  req         in   2   request per port; held high until ack/err on that port
//  req_addr0   in   10  port0 address, bits [13:4]
//  req_addr1   in   10  port1 address, bits [13:4]
//  req_rnw     in   2   per port: 1=read, 0=write
//  ack         out  2   one-cycle pulse, transaction complete on that port
//  err         out  2   one-cycle pulse, address outside window, no bus cycle
//  rdata       out  1   SDRD captured for the last read; valid with ack
//  BA          out  10  window bus address [13:4]
//  BR_W        out  1   window bus read(1)/write(0)
//  SSER        out  1   active-low select strobe to serial engine
//  SDRD        in   1   serial engine read data
//  busy        out  1   high whenever FSM not IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, ack=0, err=0, rdata=0, BA=0, BR_W=1, SSER=1, busy=0, rr pointer=port0.
//  FSM states: IDLE, SETUP, STROBE, SAMPLE, DONE.
//  IDLE: if any req, pick winner.
//   - one requester: it wins.
//   - both: winner = rr pointer.
//   rr pointer flips to the other port after every grant, including rejected ones.
//  Window check on winner address: addr[13]==0 && addr[12]==1.
//   - fail: err[winner] pulses the next cycle; stay IDLE; bus outputs unchanged.
//   - pass: latch addr/rnw into BA/BR_W; go SETUP.
//  SETUP: SSER=1 for SETUP_CYCLES cycles, then STROBE.
//  STROBE: SSER=0 for WAIT_CYCLES cycles; BA/BR_W stable throughout; then SAMPLE.
//  SAMPLE: SSER=0; if read, rdata<=SDRD at this edge; go DONE.
//  DONE: SSER=1; ack[winner]=1 for exactly this cycle; BR_W returns to 1; go IDLE.
//  Latency, req to ack (accepted, uncontended): 1 + SETUP_CYCLES + WAIT_CYCLES + 2 cycles
//   (=6 with defaults).
//  Earliest new grant is the cycle after DONE; no back-to-back overlap of SSER cycles.
//  Requester dropping req mid-transaction:
//   - transaction still completes on the bus;
//   - ack still pulses and is ignored.
//  Request changes while granted are ignored (address latched in IDLE).
//  ack and err never both high; at most one bit of ack|err set per cycle.
//  Write transactions: rdata unchanged.
//  rst asserted mid-transaction: next edge forces reset values, SSER high immediately, no ack.
// TESTING
//  T1 port0 read 0x100 alone, SDRD=1 during SAMPLE -> SSER low 3 cycles, ack[0] at cycle 6, rdata=1.
//  T2 both req same cycle after reset -> port0 served first, port1 ack 6 cycles later; rr alternates over 4 more rounds.
//  T3 port1 addr 0x200 (BA13=1) -> err[1] next cycle, SSER stays 1, busy stays 0.
//  T4 port0 write 0x1FF -> BR_W=0 during SETUP..SAMPLE, rdata unchanged, ack[0] at cycle 6.
//  T5 rst pulsed in STROBE -> SSER=1 and FSM IDLE next cycle, no ack; fresh req then completes normally.
//  T6 WAIT_CYCLES=15 build -> SSER low 16 cycles, ack 19 cycles after req.

Source files
------------

// File: rtl/ser_window_arbiter_if.sv
// ser_window_arbiter_if: requester handshake plus serial-engine window bus.
interface ser_window_arbiter_if;
    logic [1:0] req;
    logic [9:0] req_addr0;
    logic [9:0] req_addr1;
    logic [1:0] req_rnw;
    logic [1:0] ack;
    logic [1:0] err;
    logic       rdata;
    logic [9:0] BA;
    logic       BR_W;
    logic       SSER;
    logic       SDRD;
    logic       busy;
    modport master (output req, req_addr0, req_addr1, req_rnw, SDRD,
                    input  ack, err, rdata, BA, BR_W, SSER, busy);
    modport slave  (input  req, req_addr0, req_addr1, req_rnw, SDRD,
                    output ack, err, rdata, BA, BR_W, SSER, busy);
endinterface

// File: rtl/ser_window_arbiter.sv
// ser_window_arbiter: round-robin CPU/DMA access to the serial-engine register window.
module ser_window_arbiter #(
    parameter int WAIT_CYCLES  = 2,
    parameter int SETUP_CYCLES = 1
) (
    input logic clk,
    input logic rst,
    ser_window_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, SAMPLE, DONE} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic       rr, owner, win, in_win;
    logic [1:0] live, ack_q, err_q;
    logic [9:0] win_addr, ba_q;
    logic       rdata_q, brw_q, sser_q, busy_q;
    // a port whose err is pulsing this cycle still holds req, so it must not be re-granted
    always_comb begin
        live     = bus.req & ~err_q;
        win      = (live == 2'b11) ? rr : live[1];
        win_addr = win ? bus.req_addr1 : bus.req_addr0;
        in_win   = ~win_addr[9] & win_addr[8];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rr      <= 1'b0;
            owner   <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= 1'b0;
            ba_q    <= '0;
            brw_q   <= 1'b1;
            sser_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            case (state)
                IDLE: if (|live) begin
                    rr <= ~win;
                    if (in_win) begin
                        ba_q   <= win_addr;
                        brw_q  <= win ? bus.req_rnw[1] : bus.req_rnw[0];
                        owner  <= win;
                        cnt    <= 4'(SETUP_CYCLES - 1);
                        busy_q <= 1'b1;
                        state  <= SETUP;
                    end else begin
                        err_q[win] <= 1'b1;
                    end
                end
                SETUP: if (cnt == 4'd0) begin
                    sser_q <= 1'b0;
                    cnt    <= 4'(WAIT_CYCLES - 1);
                    state  <= STROBE;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                STROBE: if (cnt == 4'd0) state <= SAMPLE;
                        else cnt <= cnt - 4'd1;
                SAMPLE: begin
                    if (brw_q) rdata_q <= bus.SDRD;
                    sser_q       <= 1'b1;
                    brw_q        <= 1'b1;
                    ack_q[owner] <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.BA    = ba_q;
    assign bus.BR_W  = brw_q;
    assign bus.SSER  = sser_q;
    assign bus.busy  = busy_q;
endmodule
